// File: rtl/func_sequencer.sv
// Activation sequencer: maps each input element to two LUT reads, hands the pair to an
// external interpolator and returns the result over a valid/ready output handshake.
module func_sequencer #(
   parameter int unsigned VEC_LEN = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic signed [7:0] in_data,
   output logic        [3:0] lut_addr,
   input  logic signed [7:0] lut_data,
   output logic signed [7:0] interp_base,
   output logic signed [7:0] interp_next,
   output logic signed [7:0] interp_remaining,
   input  logic signed [7:0] interp_value,
   output logic              out_valid,
   input  logic              out_ready,
   output logic signed [7:0] out_data,
   output logic              done
);

   localparam int unsigned CntW = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;

   typedef enum logic [2:0] {
      StIdle,
      StAddr,
      StBase,
      StNext,
      StCalc,
      StOut
   } state_e;

   state_e            state_q, state_d;
   logic        [7:0] data_q, data_d;
   logic        [3:0] addr_q, addr_d;
   logic signed [7:0] base_q, base_d;
   logic signed [7:0] next_q, next_d;
   logic signed [7:0] rem_q, rem_d;
   logic signed [7:0] out_q, out_d;
   logic   [CntW-1:0] cnt_q, cnt_d;
   logic              done_q, done_d;

   logic [3:0] in_base_addr;
   logic [3:0] held_base_addr;
   logic [3:0] next_addr;
   logic [7:0] remaining;

   // Integer part of the Q4.4 input, offset-binary so -8..7 lands on 0..15.
   assign in_base_addr   = {~in_data[7], in_data[6:4]};
   assign held_base_addr = {~data_q[7], data_q[6:4]};
   assign next_addr      = (held_base_addr == 4'hF) ? 4'hF : held_base_addr + 4'd1;
   assign remaining      = {4'b0000, data_q[3:0]};

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      addr_d  = addr_q;
      base_d  = base_q;
      next_d  = next_q;
      rem_d   = rem_q;
      out_d   = out_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               data_d  = in_data;
               addr_d  = in_base_addr;
               state_d = StAddr;
            end
         end
         StAddr: begin
            addr_d  = next_addr;
            state_d = StBase;
         end
         StBase: begin
            base_d  = lut_data;
            state_d = StNext;
         end
         StNext: begin
            next_d  = lut_data;
            rem_d   = remaining;
            state_d = StCalc;
         end
         StCalc: begin
            out_d   = interp_value;
            state_d = StOut;
         end
         StOut: begin
            if (out_ready) begin
               state_d = StIdle;
               if (cnt_q == CntW'(VEC_LEN - 1)) begin
                  cnt_d  = '0;
                  done_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + CntW'(1);
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= StIdle;
         data_q  <= '0;
         addr_q  <= '0;
         base_q  <= '0;
         next_q  <= '0;
         rem_q   <= '0;
         out_q   <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         addr_q  <= addr_d;
         base_q  <= base_d;
         next_q  <= next_d;
         rem_q   <= rem_d;
         out_q   <= out_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   assign in_ready         = (state_q == StIdle);
   assign out_valid        = (state_q == StOut);
   assign lut_addr         = addr_q;
   assign interp_base      = base_q;
   assign interp_next      = next_q;
   assign interp_remaining = rem_q;
   assign out_data         = out_q;
   assign done             = done_q;

endmodule

// File: tb/tb_func_sequencer.sv
// Randomized bench for func_sequencer with a registered activation LUT and a
// behavioural interpolator; expected results come from a direct element model.
module tb_func_sequencer;

   localparam int unsigned VEC_LEN = 4;

   logic              clk;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic signed [7:0] in_data;
   logic        [3:0] lut_addr;
   logic signed [7:0] lut_data;
   logic signed [7:0] interp_base;
   logic signed [7:0] interp_next;
   logic signed [7:0] interp_remaining;
   logic signed [7:0] interp_value;
   logic              out_valid;
   logic              out_ready;
   logic signed [7:0] out_data;
   logic              done;

   int n_checks = 0;
   int n_errors = 0;
   int hs_cnt   = 0;
   int interp_tmp;

   func_sequencer #(
      .VEC_LEN(VEC_LEN)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .in_data         (in_data),
      .lut_addr        (lut_addr),
      .lut_data        (lut_data),
      .interp_base     (interp_base),
      .interp_next     (interp_next),
      .interp_remaining(interp_remaining),
      .interp_value    (interp_value),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_data        (out_data),
      .done            (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int lut_f(input int k);
      return (k < 8) ? 0 : (k - 8) * 16;
   endfunction

   // LUT with one cycle of read latency.
   initial lut_data = '0;
   always @(posedge clk) lut_data <= 8'(lut_f(int'(lut_addr)));

   always_comb begin
      interp_tmp   = (int'(interp_next) - int'(interp_base)) * int'(interp_remaining);
      interp_value = 8'(int'(interp_base) + (interp_tmp >>> 4));
   end

   function automatic int base_idx(input logic [7:0] x);
      return (int'($signed(x)) >>> 4) + 8;
   endfunction

   function automatic int next_idx(input logic [7:0] x);
      return (base_idx(x) == 15) ? 15 : base_idx(x) + 1;
   endfunction

   function automatic int model_out(input logic [7:0] x);
      int b;
      int n;
      int r;
      b = lut_f(base_idx(x));
      n = lut_f(next_idx(x));
      r = int'(x[3:0]);
      return int'($signed(8'(b + (((n - b) * r) >>> 4))));
   endfunction

   task automatic check_eq(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One element through the full pipeline; stall = OUT cycles with out_ready low.
   task automatic send_elem(input logic [7:0] x, input int stall, input int exp_out);
      in_valid  = 1'b1;
      in_data   = x;
      out_ready = (stall == 0);
      check_eq("in_ready_idle", int'(in_ready), 1);
      step();
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      check_eq("addr_base", int'(lut_addr), base_idx(x));
      check_eq("busy_c1", int'(in_ready), 0);
      check_eq("ov_c1", int'(out_valid), 0);
      check_eq("done_c1", int'(done), 0);
      step();
      check_eq("addr_next", int'(lut_addr), next_idx(x));
      check_eq("ov_c2", int'(out_valid), 0);
      step();
      check_eq("interp_base", int'(interp_base), lut_f(base_idx(x)));
      check_eq("ov_c3", int'(out_valid), 0);
      step();
      check_eq("interp_next", int'(interp_next), lut_f(next_idx(x)));
      check_eq("interp_rem", int'(interp_remaining), int'(x[3:0]));
      check_eq("ov_c4", int'(out_valid), 0);
      step();
      for (int i = 0; i < stall; i++) begin
         check_eq("ov_stall", int'(out_valid), 1);
         check_eq("od_stall", int'(out_data), exp_out);
         check_eq("busy_stall", int'(in_ready), 0);
         check_eq("done_stall", int'(done), 0);
         in_valid = 1'($urandom_range(0, 1));
         in_data  = 8'($urandom);
         step();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check_eq("ov_out", int'(out_valid), 1);
      check_eq("out_data", int'(out_data), exp_out);
      step();
      out_ready = 1'b0;
      hs_cnt++;
      check_eq("done", int'(done), (hs_cnt % VEC_LEN == 0) ? 1 : 0);
      check_eq("ov_after", int'(out_valid), 0);
      check_eq("ready_after", int'(in_ready), 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [7:0] x;
      rst       = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      repeat (3) step();
      check_eq("rst_ready", int'(in_ready), 1);
      check_eq("rst_addr", int'(lut_addr), 0);
      check_eq("rst_ov", int'(out_valid), 0);
      check_eq("rst_od", int'(out_data), 0);
      check_eq("rst_done", int'(done), 0);
      rst = 1'b1;
      step();
      check_eq("ready_post_rst", int'(in_ready), 1);

      send_elem(8'h0A, 0, 10);
      send_elem(8'h25, 0, 37);
      send_elem(8'h7F, 0, 112);
      send_elem(8'h0A, 0, 10);
      step();
      check_eq("done_one_cycle", int'(done), 0);
      send_elem(8'hFD, 7, 0);

      // Reset while the element sits in BASE.
      in_valid = 1'b1;
      in_data  = 8'h25;
      step();
      in_valid = 1'b0;
      step();
      rst = 1'b0;
      step();
      check_eq("mid_rst_ready", int'(in_ready), 1);
      check_eq("mid_rst_addr", int'(lut_addr), 0);
      check_eq("mid_rst_base", int'(interp_base), 0);
      check_eq("mid_rst_next", int'(interp_next), 0);
      check_eq("mid_rst_rem", int'(interp_remaining), 0);
      check_eq("mid_rst_od", int'(out_data), 0);
      check_eq("mid_rst_ov", int'(out_valid), 0);
      check_eq("mid_rst_done", int'(done), 0);
      rst = 1'b1;
      hs_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         check_eq("no_ov_after_rst", int'(out_valid), 0);
         check_eq("no_done_after_rst", int'(done), 0);
      end
      send_elem(8'h25, 0, 37);
      send_elem(8'h7F, 2, 112);
      send_elem(8'hFD, 0, 0);
      send_elem(8'h0A, 1, 10);

      for (int n = 0; n < 24; n++) begin
         x = 8'($urandom);
         repeat ($urandom_range(0, 2)) begin
            step();
            check_eq("idle_ready", int'(in_ready), 1);
         end
         send_elem(x, $urandom_range(0, 4), model_out(x));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/func_sequencer.md
FUNC_SEQUENCER -- requirements
Module: func_sequencer

Interface
REQ-001 SHALL have parameter VEC_LEN, default 4, meaning elements per vector; the done pulse fires after this many outputs.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous, active-low.
REQ-004 SHALL have port in_valid, input, 1 bit: the in_data element is offered.
REQ-005 SHALL have port in_ready, output, 1 bit: the block accepts an element this cycle.
REQ-006 SHALL have port in_data, input, signed 8 bit: pre-activation value, 4 fractional bits.
REQ-007 SHALL have port lut_addr, output, 4 bit (registered): activation LUT read address.
REQ-008 SHALL have port lut_data, input, signed 8 bit: the LUT entry for lut_addr of the previous cycle (1-cycle read latency).
REQ-009 SHALL have ports interp_base, interp_next and interp_remaining, outputs, signed 8 bit each (registered): operands for the interpolator.
REQ-010 SHALL have port interp_value, input, signed 8 bit: combinational interpolator result.
REQ-011 SHALL have port out_valid, output, 1 bit: out_data holds a result.
REQ-012 SHALL have port out_ready, input, 1 bit: the consumer accepts out_data.
REQ-013 SHALL have port out_data, output, signed 8 bit (registered): activated value.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse marking the last element of a vector.

Function
REQ-015 SHALL implement the FSM states IDLE, ADDR, BASE, NEXT, CALC and OUT, with in_ready=1 only in IDLE.
REQ-016 SHALL, in IDLE on in_valid=1, capture in_data, load lut_addr<=base_addr and move to ADDR; otherwise it SHALL stay in IDLE.
REQ-017 SHALL form base_addr = {~in_data[7], in_data[6:4]}, giving a signed integer part in -8..7 mapped to 0..15.
REQ-018 SHALL form next_addr = base_addr+1, saturating at 15, so base_addr=15 gives next_addr=15.
REQ-019 SHALL form remaining = {4'b0000, in_data[3:0]}, an unsigned value 0..15.
REQ-020 SHALL, in ADDR, load lut_addr<=next_addr and move to BASE.
REQ-021 SHALL, in BASE, capture interp_base<=lut_data and move to NEXT.
REQ-022 SHALL, in NEXT, capture interp_next<=lut_data and interp_remaining<=remaining, then move to CALC.
REQ-023 SHALL, in CALC, capture out_data<=interp_value and move to OUT.
REQ-024 SHALL hold out_valid=1 in OUT, with out_data stable, until out_ready=1.
REQ-025 SHALL, in OUT, return to IDLE on out_ready=1; the handshake completes that cycle.
REQ-026 SHALL raise out_valid exactly 5 cycles after the accepting cycle when out_ready is held high.
REQ-027 SHALL take 6 cycles per element at minimum; a new element SHALL NOT be accepted before the previous output handshake.
REQ-028 SHALL, in OUT, ignore in_valid; in_ready SHALL be 0 there.
REQ-029 SHALL count each output handshake in elem_cnt (0..VEC_LEN-1).
REQ-030 SHALL, on the handshake with elem_cnt=VEC_LEN-1, pulse done=1 in the next cycle and wrap elem_cnt to 0.
REQ-031 SHALL keep done=0 in all other cycles.
REQ-032 SHALL NOT perform any arithmetic internally; all interpolation is done by the external interpolator (base + ((next-base)*remaining)>>4, 8-bit wrap).

Reset
REQ-033 SHALL, when rst=0 at a clock edge, force state to IDLE and elem_cnt to 0.
REQ-034 SHALL, when rst=0 at a clock edge, clear lut_addr, interp_base, interp_next, interp_remaining, out_data, out_valid and done to 0.
REQ-035 SHALL abandon any in-flight element when reset arrives mid-operation (any state), with no out_valid and no done for it.
REQ-036 SHALL drive in_ready=1 in the first cycle after rst returns to 1.

Verification
Bench LUT: LUT[k] = 0 for k<8, LUT[k] = (k-8)*16 otherwise; the interpolator is instantiated as the reference model.
REQ-037 in_data=0x25 -> lut_addr 10 then 11; base=32, next=48, remaining=5; out_data=37, with out_valid 5 cycles after accept.
REQ-038 in_data=0xFD (-3) -> addresses 7 then 8; remaining=13; out_data=0.
REQ-039 in_data=0x7F -> addresses 15 then 15 (saturated); remaining=15; out_data=112.
REQ-040 Four elements 0x0A, 0x25, 0x7F, 0x0A with out_ready=1 -> outputs 10, 37, 112, 10; done is high only in the cycle after the 4th handshake, and elem_cnt returns to 0.
REQ-041 out_ready held 0 for 7 cycles in OUT -> out_valid stays 1, out_data is unchanged, in_ready=0 and in_valid is ignored.
REQ-042 rst=0 asserted while in BASE -> the next cycle shows IDLE with all outputs 0; no out_valid follows, and the next vector needs 4 fresh elements before done.
